i2c_slave_byte_engine: RTL and testbench

//  Bit-level I2C slave front end that sits directly upstream of the frame bridge.
//  - Watches SCL/SDA and detects START, repeated START and STOP.
//  - Matches the 7-bit device address, shifts bytes in and out MSB first, and generates ACK.
//  - Presents byte-level strobes (rx_valid, tx_valid, sr_start, inframe, edge_detect) to the bridge.
//  - Drives SDA open-drain through sda_oe only; never drives SDA high.

---
 rtl/i2c_slave_byte_engine.sv | 262 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_byte_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_byte_engine.sv
// Bit-level I2C slave: START/STOP detection, address match, byte shift in/out and ACK generation.
// Optional SCL/SDA glitch filter enabled by defining I2C_GLITCH_FILTER_EN.
//
// state     | meaning
// IDLE      | bus free or reset, waiting for START
// ADDR      | shifting in the address byte
// ADDR_ACK  | driving ACK for a matched address
// RX_BYTE   | shifting in a write data byte
// RX_ACK    | driving ACK for a received data byte
// TX_BYTE   | shifting out a read data byte
// TX_ACK    | SDA released, sampling the master's ACK/NACK
// WAIT_STOP | not addressed or master NACKed; SDA never driven
module i2c_slave_byte_engine #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       sr_start,
  output logic       inframe,
  output logic       rw_bit,
  output logic       addr_match,
  output logic       edge_detect
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_s, sda_s, scl_f, sda_f;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
  end

  // Idle bus level is high, so synchronisers reset to 1 to avoid a false START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic [FCW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

  always_comb begin
    scl_filt_d = scl_filt_q;
    scl_cnt_d  = '0;
    if (scl_s != scl_filt_q) begin
      if (scl_cnt_q == FCW'(FILTER_LEN - 1)) scl_filt_d = scl_s;
      else scl_cnt_d = scl_cnt_q + 1'b1;
    end
    sda_filt_d = sda_filt_q;
    sda_cnt_d  = '0;
    if (sda_s != sda_filt_q) begin
      if (sda_cnt_q == FCW'(FILTER_LEN - 1)) sda_filt_d = sda_s;
      else sda_cnt_d = sda_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
    end else begin
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
    end
  end

  assign scl_f = scl_filt_q;
  assign sda_f = sda_filt_q;
`else
  localparam int unused_filter_len = FILTER_LEN;
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  always_comb begin
    scl_prev_d = scl_f;
    sda_prev_d = sda_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  logic start_det, stop_det, scl_rise, scl_fall;
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;

  state_t     state_q;
  logic [7:0] shift_q, rx_data_q;
  logic [2:0] bit_cnt_q;
  logic       ack_q, sda_oe_q, rx_valid_q, tx_valid_q, sr_start_q;
  logic       inframe_q, rw_bit_q, addr_match_q, edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      rx_data_q    <= '0;
      bit_cnt_q    <= '0;
      ack_q        <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      sr_start_q   <= 1'b0;
      inframe_q    <= 1'b0;
      rw_bit_q     <= 1'b0;
      addr_match_q <= 1'b0;
      edge_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_valid_q <= 1'b0;
      sr_start_q <= 1'b0;
      edge_q     <= scl_rise;
      if (stop_det) begin
        state_q      <= IDLE;
        inframe_q    <= 1'b0;
        addr_match_q <= 1'b0;
        sda_oe_q     <= 1'b0;
        bit_cnt_q    <= '0;
        ack_q        <= 1'b0;
      end else if (start_det) begin
        state_q      <= ADDR;
        inframe_q    <= 1'b1;
        sr_start_q   <= inframe_q;
        addr_match_q <= 1'b0;
        sda_oe_q     <= 1'b0;
        bit_cnt_q    <= '0;
        ack_q        <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_f};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rw_bit_q <= sda_f;
                if (shift_q[6:0] == SLAVE_ADDR) begin
                  addr_match_q <= 1'b1;
                  ack_q        <= 1'b1;
                end else begin
                  state_q <= WAIT_STOP;
                end
              end
            end else if (scl_fall && ack_q) begin
              ack_q    <= 1'b0;
              sda_oe_q <= 1'b1;
              state_q  <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_bit_q) begin
                tx_valid_q <= 1'b1;
                state_q    <= TX_BYTE;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= RX_BYTE;
              end
            end
          end
          RX_BYTE: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_f};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                rx_data_q  <= {shift_q[6:0], sda_f};
                rx_valid_q <= 1'b1;
                ack_q      <= 1'b1;
              end
            end else if (scl_fall && ack_q) begin
              ack_q    <= 1'b0;
              sda_oe_q <= 1'b1;
              state_q  <= RX_ACK;
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= RX_BYTE;
            end
          end
          TX_BYTE: begin
            // tx_data is taken in the cycle tx_valid is high, so bit7 goes out one clk later
            if (tx_valid_q) begin
              shift_q   <= tx_data;
              sda_oe_q  <= ~tx_data[7];
              bit_cnt_q <= '0;
            end else if (scl_fall) begin
              if (bit_cnt_q == 3'd7) begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= TX_ACK;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                sda_oe_q  <= ~shift_q[6];
                shift_q   <= {shift_q[6:0], 1'b0};
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_f) ack_q <= 1'b1;
              else state_q <= WAIT_STOP;
            end else if (scl_fall && ack_q) begin
              ack_q      <= 1'b0;
              tx_valid_q <= 1'b1;
              state_q    <= TX_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe      = sda_oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_valid    = tx_valid_q;
  assign sr_start    = sr_start_q;
  assign inframe     = inframe_q;
  assign rw_bit      = rw_bit_q;
  assign addr_match  = addr_match_q;
  assign edge_detect = edge_q;

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Bench for i2c_slave_byte_engine: bit-banged I2C master plus a transaction-level expectation model.
module tb_i2c_slave_byte_engine;
  localparam int H = 16;
  localparam logic [6:0] ADDR7 = 7'h50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_in = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;
  logic sda_oe, rx_valid, tx_valid, sr_start, inframe, rw_bit, addr_match, edge_detect;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;

  int n_chk = 0;
  int n_fail = 0;

  int rx_cnt = 0, tx_cnt = 0, sr_cnt = 0, edge_cnt = 0, oe_cnt = 0, tx_loads = 0;
  logic txv_d = 1'b0;
  logic [7:0] rx_log[64];
  logic [7:0] tx_bytes[8];

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_byte_engine dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_bus), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .sr_start(sr_start), .inframe(inframe), .rw_bit(rw_bit), .addr_match(addr_match),
    .edge_detect(edge_detect)
  );

  always #5 clk = ~clk;

  // Passive monitor; tx_data advances only after the posedge that consumed it.
  always @(negedge clk) begin
    if (rx_valid) begin rx_log[rx_cnt % 64] = rx_data; rx_cnt++; end
    if (tx_valid) tx_cnt++;
    if (sr_start) sr_cnt++;
    if (edge_detect) edge_cnt++;
    if (sda_oe) oe_cnt++;
    if (txv_d) tx_loads++;
    txv_d = tx_valid;
    tx_data = tx_bytes[tx_loads % 8];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    wait_clk(4); sda_m = 1'b1; wait_clk(H - 4);
    scl_in = 1'b1; wait_clk(H);
    sda_m = 1'b0; wait_clk(H);
    scl_in = 1'b0;
  endtask

  task automatic m_stop();
    wait_clk(4); sda_m = 1'b0; wait_clk(H - 4);
    scl_in = 1'b1; wait_clk(H);
    sda_m = 1'b1; wait_clk(H);
  endtask

  task automatic write_bit(input logic b);
    wait_clk(4); sda_m = b; wait_clk(H - 4);
    scl_in = 1'b1; wait_clk(H);
    scl_in = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clk(4); sda_m = 1'b1; wait_clk(H - 4);
    scl_in = 1'b1; wait_clk(H / 2);
    b = sda_bus; wait_clk(H / 2);
    scl_in = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin read_bit(b); d[i] = b; end
    write_bit(nack);
  endtask

  task automatic test_reset();
    scl_in = 1'b1; sda_m = 1'b1; rst_n = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    n_chk++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
    n_chk++; if ({rx_valid, tx_valid, sr_start, edge_detect} !== 4'b0) begin n_fail++;
      $display("FAIL reset_pulses got %b want 0000", {rx_valid, tx_valid, sr_start, edge_detect}); end
    n_chk++; if ({inframe, rw_bit, addr_match} !== 3'b0) begin n_fail++;
      $display("FAIL reset_levels got %b want 000", {inframe, rw_bit, addr_match}); end
    n_chk++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
  endtask

  // Write transaction to our address: every byte ACKed, every data byte reported in order.
  task automatic do_write(input int n, input logic [7:0] d[4]);
    int rx0, oe0;
    logic ack;
    rx0 = rx_cnt;
    m_start();
    n_chk++; if (inframe !== 1'b1) begin n_fail++; $display("FAIL wr_inframe_start got %b want 1", inframe); end
    oe0 = oe_cnt;
    write_byte({ADDR7, 1'b0}, ack);
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_addr_ack got %b want 1", ack); end
    n_chk++; if (oe_cnt == oe0) begin n_fail++; $display("FAIL wr_addr_oe got %0d cycles want >0", oe_cnt - oe0); end
    n_chk++; if ({addr_match, rw_bit} !== 2'b10) begin n_fail++;
      $display("FAIL wr_match_rw got %b want 10", {addr_match, rw_bit}); end
    for (int k = 0; k < n; k++) begin
      write_byte(d[k], ack);
      n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wr_data_ack byte %0d got %b want 1", k, ack); end
    end
    m_stop();
    n_chk++; if (inframe !== 1'b0) begin n_fail++; $display("FAIL wr_inframe_stop got %b want 0", inframe); end
    n_chk++; if (rx_cnt - rx0 != n) begin n_fail++; $display("FAIL wr_rx_count got %0d want %0d", rx_cnt - rx0, n); end
    for (int k = 0; k < n; k++) begin
      n_chk++; if (rx_log[(rx0 + k) % 64] !== d[k]) begin n_fail++;
        $display("FAIL wr_rx_data byte %0d got %h want %h", k, rx_log[(rx0 + k) % 64], d[k]); end
    end
  endtask

  task automatic test_write();
    logic [7:0] d[4];
    d[0] = 8'h12; d[1] = 8'h34; d[2] = 8'h00; d[3] = 8'h00;
    do_write(2, d);
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      do_write(int'($urandom_range(1, 4)), d);
    end
  endtask

  task automatic test_no_match();
    logic [7:0] a;
    logic ack;
    int rx0, oe0;
    for (int t = 0; t < 3; t++) begin
      if (t == 0) a = 8'hA2;
      else begin
        a = 8'($urandom);
        if (a[7:1] == ADDR7) a[7] = ~a[7];
      end
      rx0 = rx_cnt; oe0 = oe_cnt;
      m_start();
      write_byte(a, ack);
      n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL nm_addr_ack addr %h got %b want 0", a, ack); end
      n_chk++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL nm_addr_match got %b want 0", addr_match); end
      write_byte(8'h55, ack);
      n_chk++; if (inframe !== 1'b1) begin n_fail++; $display("FAIL nm_inframe got %b want 1", inframe); end
      m_stop();
      n_chk++; if (inframe !== 1'b0) begin n_fail++; $display("FAIL nm_inframe_stop got %b want 0", inframe); end
      n_chk++; if (oe_cnt != oe0) begin n_fail++; $display("FAIL nm_sda_oe got %0d cycles want 0", oe_cnt - oe0); end
      n_chk++; if (rx_cnt != rx0) begin n_fail++; $display("FAIL nm_rx_valid got %0d want 0", rx_cnt - rx0); end
    end
  endtask

  // Write register pointer, repeated START, then read n bytes with the last one NACKed.
  task automatic do_read(input int n, input logic [7:0] d[4]);
    int base, sr0, tx0;
    logic ack;
    logic [7:0] got;
    base = tx_loads;
    for (int k = 0; k < n; k++) tx_bytes[(base + k) % 8] = d[k];
    sr0 = sr_cnt; tx0 = tx_cnt;
    m_start();
    write_byte({ADDR7, 1'b0}, ack);
    write_byte(8'h00, ack);
    write_byte(8'h10, ack);
    m_start();
    write_byte({ADDR7, 1'b1}, ack);
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ack got %b want 1", ack); end
    n_chk++; if (sr_cnt - sr0 != 1) begin n_fail++; $display("FAIL rd_sr_start got %0d want 1", sr_cnt - sr0); end
    n_chk++; if (rw_bit !== 1'b1) begin n_fail++; $display("FAIL rd_rw_bit got %b want 1", rw_bit); end
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, got);
      n_chk++; if (got !== d[k]) begin n_fail++; $display("FAIL rd_data byte %0d got %h want %h", k, got, d[k]); end
    end
    wait_clk(H);
    n_chk++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rd_release got %b want 0", sda_oe); end
    m_stop();
    n_chk++; if (tx_cnt - tx0 != n) begin n_fail++; $display("FAIL rd_tx_valid got %0d want %0d", tx_cnt - tx0, n); end
    n_chk++; if (inframe !== 1'b0) begin n_fail++; $display("FAIL rd_inframe_stop got %b want 0", inframe); end
  endtask

  task automatic test_read();
    logic [7:0] d[4];
    d[0] = 8'hDE; d[1] = 8'hAD; d[2] = 8'hBE; d[3] = 8'hEF;
    do_read(4, d);
    for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
    do_read(int'($urandom_range(1, 4)), d);
  endtask

  task automatic test_stop_abort();
    logic ack;
    int rx0;
    rx0 = rx_cnt;
    m_start();
    write_byte({ADDR7, 1'b0}, ack);
    for (int i = 0; i < 3; i++) write_bit(1'($urandom));
    m_stop();
    n_chk++; if (rx_cnt != rx0) begin n_fail++; $display("FAIL ab_rx_valid got %0d want 0", rx_cnt - rx0); end
    n_chk++; if ({sda_oe, inframe, addr_match} !== 3'b000) begin n_fail++;
      $display("FAIL ab_idle got %b want 000", {sda_oe, inframe, addr_match}); end
    m_start();
    write_byte({ADDR7, 1'b0}, ack);
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL ab_reack got %b want 1", ack); end
    m_stop();
  endtask

  task automatic test_async_reset();
    logic [7:0] a;
    logic [7:0] d[4];
    int w;
    a = {ADDR7, 1'b0};
    m_start();
    for (int i = 7; i >= 0; i--) write_bit(a[i]);
    w = 0;
    while (sda_oe !== 1'b1 && w < 4 * H) begin @(negedge clk); w++; end
    n_chk++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL ar_ack_timeout got %b want 1", sda_oe); end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_chk++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL ar_sda_oe_async got %b want 0", sda_oe); end
    n_chk++; if ({rx_valid, tx_valid, sr_start, inframe, rw_bit, addr_match, edge_detect} !== 7'b0) begin n_fail++;
      $display("FAIL ar_outputs got %b want 0", {rx_valid, tx_valid, sr_start, inframe, rw_bit, addr_match, edge_detect}); end
    sda_m = 1'b1; wait_clk(2); scl_in = 1'b1; wait_clk(4);
    rst_n = 1'b1; wait_clk(4);
    d[0] = 8'h5A; d[1] = 8'hC3; d[2] = 8'h00; d[3] = 8'h00;
    do_write(2, d);
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    logic ack, b;
    int e0, rx0;
    d = 8'($urandom);
    m_start();
    write_byte({ADDR7, 1'b0}, ack);
    e0 = edge_cnt; rx0 = rx_cnt;
    for (int i = 7; i >= 5; i--) write_bit(d[i]);
    wait_clk(4); scl_in = 1'b1; wait_clk(1); scl_in = 1'b0;
    for (int i = 4; i >= 1; i--) write_bit(d[i]);
`ifndef I2C_GLITCH_FILTER_EN
    n_chk++; if (rx_cnt - rx0 != 1) begin n_fail++; $display("FAIL gl_early_rx got %0d want 1", rx_cnt - rx0); end
`endif
    write_bit(d[0]);
`ifdef I2C_GLITCH_FILTER_EN
    n_chk++; if (edge_cnt - e0 != 8) begin n_fail++; $display("FAIL gl_edges got %0d want 8", edge_cnt - e0); end
    n_chk++; if (rx_cnt - rx0 != 1) begin n_fail++; $display("FAIL gl_rx_count got %0d want 1", rx_cnt - rx0); end
    n_chk++; if (rx_log[rx0 % 64] !== d) begin n_fail++; $display("FAIL gl_rx_data got %h want %h", rx_log[rx0 % 64], d); end
`else
    n_chk++; if (edge_cnt - e0 != 9) begin n_fail++; $display("FAIL gl_edges got %0d want 9", edge_cnt - e0); end
`endif
    read_bit(b);
    m_stop();
    n_chk++; if ({sda_oe, inframe} !== 2'b00) begin n_fail++; $display("FAIL gl_idle got %b want 00", {sda_oe, inframe}); end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) tx_bytes[k] = 8'h00;
    test_reset();
    test_write();
    test_no_match();
    test_read();
    test_stop_abort();
    test_async_reset();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
